// File: rtl/sha_pad.sv
// sha_pad: byte stream to 64-byte SHA-256 blocks with 0x80/zero/length padding and Enable/Function handshake.
// Optional SHA_PAD_BYPASS_EN adds Pad_Bypass: message is zero-filled to a block boundary without padding.
module sha_pad #(
    parameter int NB_BYTES  = 64,
    parameter int LEN_BYTES = 8,
    parameter int CNT_W     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               In_Data,
    input  logic                     In_Valid,
    input  logic                     In_Last,
    output logic                     In_Ready,
    output logic [NB_BYTES-1:0][7:0] Data_Block,
    output logic                     Enable,
    output logic                     Function,
`ifdef SHA_PAD_BYPASS_EN
    input  logic                     Pad_Bypass,
`endif
    input  logic                     Core_Ready
);
    localparam int AW = $clog2(NB_BYTES);
    localparam int IW = AW + 1;
    localparam logic [IW-1:0] LAST   = IW'(NB_BYTES - 1);
    localparam logic [IW-1:0] LEN_AT = IW'(NB_BYTES - LEN_BYTES);
    localparam logic [IW-1:0] FULL   = IW'(NB_BYTES);

    typedef enum logic [2:0] {IDLE, FILL, PAD, ZERO, LEN, ISSUE, WAIT} state_t;

    state_t            state;
    logic [IW-1:0]     idx;
    logic [CNT_W-1:0]  bitcnt;
    logic              first, pad_pending, len_owed, final_blk, to_len;
    logic              accept, raw_last;
    logic [IW-1:0]     idx_n, ztgt, rem;
    logic [7:0]        len_byte;

    assign In_Ready = rst && (state == IDLE || state == FILL);
    assign accept   = In_Valid && In_Ready;
    assign idx_n    = idx + 1'b1;
    assign ztgt     = to_len ? LEN_AT : FULL;
    assign rem      = LAST - idx;
    assign len_byte = 8'(bitcnt >> {rem, 3'b000});

`ifdef SHA_PAD_BYPASS_EN
    logic byp;
    assign raw_last = In_Last && (state == IDLE ? Pad_Bypass : byp);
    always_ff @(posedge clk or negedge rst)
        if (!rst) byp <= 1'b0;
        else if (state == IDLE && accept) byp <= Pad_Bypass;
`else
    assign raw_last = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            idx         <= '0;
            bitcnt      <= '0;
            first       <= 1'b1;
            pad_pending <= 1'b0;
            len_owed    <= 1'b0;
            final_blk   <= 1'b0;
            to_len      <= 1'b0;
            Data_Block  <= '0;
            Enable      <= 1'b0;
            Function    <= 1'b0;
        end else begin
            Enable <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    Data_Block[0] <= In_Data;
                    idx         <= IW'(1);
                    bitcnt      <= CNT_W'(8);
                    first       <= 1'b1;
                    pad_pending <= 1'b0;
                    len_owed    <= 1'b0;
                    final_blk   <= raw_last;
                    to_len      <= 1'b0;
                    state       <= !In_Last ? FILL : raw_last ? ZERO : PAD;
                end
                FILL: if (accept) begin
                    Data_Block[idx[AW-1:0]] <= In_Data;
                    idx    <= idx_n;
                    bitcnt <= bitcnt + CNT_W'(8);
                    if (idx == LAST) begin
                        pad_pending <= In_Last && !raw_last;
                        final_blk   <= raw_last;
                        state       <= ISSUE;
                    end else if (In_Last) begin
                        final_blk <= raw_last;
                        to_len    <= 1'b0;
                        state     <= raw_last ? ZERO : PAD;
                    end
                end
                PAD: begin
                    Data_Block[idx[AW-1:0]] <= 8'h80;
                    idx <= idx_n;
                    if (idx_n <= LEN_AT) begin
                        to_len <= 1'b1;
                        state  <= idx_n == LEN_AT ? LEN : ZERO;
                    end else begin
                        // no room for the length field: it goes into an extra block
                        to_len   <= 1'b0;
                        len_owed <= 1'b1;
                        state    <= idx_n == FULL ? ISSUE : ZERO;
                    end
                end
                ZERO: begin
                    Data_Block[idx[AW-1:0]] <= 8'h00;
                    idx <= idx_n;
                    if (idx_n == ztgt) state <= to_len ? LEN : ISSUE;
                end
                LEN: begin
                    Data_Block[idx[AW-1:0]] <= len_byte;
                    idx <= idx_n;
                    if (idx == LAST) begin
                        final_blk <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    Enable   <= 1'b1;
                    Function <= !first;
                    first    <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: if (Core_Ready) begin
                    idx <= '0;
                    if (pad_pending) begin
                        pad_pending <= 1'b0;
                        state       <= PAD;
                    end else if (len_owed) begin
                        len_owed <= 1'b0;
                        to_len   <= 1'b1;
                        state    <= ZERO;
                    end else state <= final_blk ? IDLE : FILL;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha_pad.sv
// tb_sha_pad: table-driven message vectors against a reference SHA-256 padding model, plus reset-mid-message sequence.
module tb_sha_pad;
    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [7:0]      In_Data = '0;
    logic            In_Valid = 1'b0, In_Last = 1'b0, Core_Ready = 1'b0;
    logic            In_Ready, Enable, Function;
    logic [63:0][7:0] Data_Block;

    always #5 clk = ~clk;

    sha_pad dut (
        .clk(clk), .rst(rst), .In_Data(In_Data), .In_Valid(In_Valid), .In_Last(In_Last),
        .In_Ready(In_Ready), .Data_Block(Data_Block), .Enable(Enable), .Function(Function),
`ifdef SHA_PAD_BYPASS_EN
        .Pad_Bypass(1'b0),
`endif
        .Core_Ready(Core_Ready)
    );

    typedef struct {
        int         n;
        logic [7:0] base;
        logic [7:0] step;
        int         nblk;
        int         hold;
    } vec_t;

    int         checks = 0, errors = 0;
    vec_t       vecs[7];
    logic [7:0] exp_msg [0:255];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic build(input vec_t v);
        int total;
        logic [63:0] bits;
        total = v.nblk * 64;
        for (int i = 0; i < total; i++) exp_msg[i] = 8'h00;
        for (int i = 0; i < v.n; i++) exp_msg[i] = 8'(v.base + v.step * i);
        exp_msg[v.n] = 8'h80;
        bits = 64'(v.n) * 8;
        for (int k = 0; k < 8; k++) exp_msg[total-1-k] = 8'(bits >> (8 * k));
    endtask

    task automatic send(input vec_t v, input bit mark_last);
        int t;
        for (int i = 0; i < v.n; i++) begin
            In_Data  = 8'(v.base + v.step * i);
            In_Valid = 1'b1;
            In_Last  = mark_last && (i == v.n - 1);
            t = 0;
            while (!In_Ready && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (t >= 500) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: byte %0d never accepted", i);
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        In_Valid = 1'b0;
        In_Last  = 1'b0;
    endtask

    task automatic collect(input vec_t v);
        int t, mism, bad;
        logic ok;
        logic [63:0][7:0] snap;
        for (int b = 0; b < v.nblk; b++) begin
            t = 0;
            while (!Enable && t < 3000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 3000) begin
                checks++;
                errors++;
                $display("FAIL enable_timeout: n=%0d block %0d never issued", v.n, b);
                return;
            end
            check($sformatf("function n=%0d blk%0d", v.n, b), 64'(Function), 64'(b != 0));
            mism = -1;
            bad = 0;
            for (int j = 0; j < 64; j++)
                if (Data_Block[j] !== exp_msg[b*64+j] && mism < 0) mism = j;
            checks++;
            if (mism >= 0) begin
                errors++;
                $display("FAIL block n=%0d blk%0d byte %0d: got %02h expected %02h",
                         v.n, b, mism, Data_Block[mism], exp_msg[b*64+mism]);
            end
            check($sformatf("in_ready_wait n=%0d blk%0d", v.n, b), 64'(In_Ready), 64'(0));
            snap = Data_Block;
            if (v.hold > 0) begin
                ok = 1'b1;
                repeat (v.hold) begin
                    @(negedge clk);
                    if (Data_Block !== snap || Enable !== 1'b0 || In_Ready !== 1'b0) ok = 1'b0;
                end
                check($sformatf("hold_stable n=%0d blk%0d", v.n, b), 64'(ok), 64'(1));
            end
            Core_Ready = 1'b1;
            @(negedge clk);
            Core_Ready = 1'b0;
        end
        check($sformatf("back_to_idle n=%0d", v.n), 64'(In_Ready), 64'(1));
    endtask

    task automatic quiet(input string name, input int cyc);
        int cnt;
        cnt = 0;
        repeat (cyc) begin
            @(negedge clk);
            if (Enable) cnt++;
        end
        check(name, 64'(cnt), 64'(0));
    endtask

    initial begin
        vec_t partial;
        vecs[0] = '{3,   8'h61, 8'h01, 1, 0};
        vecs[1] = '{55,  8'h00, 8'h00, 1, 2};
        vecs[2] = '{56,  8'h10, 8'h03, 2, 0};
        vecs[3] = '{64,  8'hA0, 8'h01, 2, 20};
        vecs[4] = '{63,  8'h05, 8'h07, 2, 1};
        vecs[5] = '{119, 8'h33, 8'h0B, 2, 0};
        vecs[6] = '{120, 8'hF0, 8'h01, 3, 3};

        repeat (2) @(negedge clk);
        check("rst_block_zero", 64'(Data_Block == '0), 64'(1));
        check("rst_enable", 64'(Enable), 64'(0));
        check("rst_in_ready", 64'(In_Ready), 64'(0));
        check("rst_function", 64'(Function), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 64'(In_Ready), 64'(1));

        for (int v = 0; v < 7; v++) begin
            build(vecs[v]);
            fork
                send(vecs[v], 1'b1);
                collect(vecs[v]);
            join
            quiet($sformatf("no_extra_enable n=%0d", vecs[v].n), 80);
        end

        partial = '{30, 8'h11, 8'h01, 0, 0};
        send(partial, 1'b0);
        check("mid_in_ready", 64'(In_Ready), 64'(1));
        rst = 1'b0;
        #1;
        check("mid_rst_block_zero", 64'(Data_Block == '0), 64'(1));
        check("mid_rst_enable", 64'(Enable), 64'(0));
        check("mid_rst_in_ready", 64'(In_Ready), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        quiet("no_enable_after_reset", 5);
        build(vecs[0]);
        fork
            send(vecs[0], 1'b1);
            collect(vecs[0]);
        join
        quiet("no_extra_enable after_reset", 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sha_pad.md
Name: sha_pad

Overview:
- Message front-end for the SHA datapath: accepts a byte stream and writes complete 64-byte message blocks.
- Appends standard SHA-256 padding: 0x80, zero bytes, then the 64-bit big-endian message bit length.
- Presents each block on Data_Block with an Enable/Function command, matching the inputs the block/schedule stage consumes.
- Waits for the downstream Ready before overwriting the buffer.

Parameters:
NB_BYTES, 64, bytes per message block (Nd of sha_const)
LEN_BYTES, 8, bytes of the appended length field
CNT_W, 64, width of the message bit-length counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active low (rst==0 resets)
In_Data  input  8  message byte
In_Valid  input  1  In_Data valid
In_Last  input  1  qualifies the current byte as the final message byte
In_Ready  output  1  byte accepted when In_Valid && In_Ready at clk edge
Data_Block  output  8 x NB_BYTES  block buffer, byte 0 = first message byte
Enable  output  1  one-cycle pulse: block on Data_Block is valid
Function  output  1  0 = first block of message (reinit hash), 1 = continuation
Core_Ready  input  1  downstream has finished consuming the issued block

Behaviour:
- Reset (rst==0, async):
  - state=IDLE; byte index=0; bit count=0; first=1; pad_pending=0.
  - Data_Block all 0x00; Enable=0; Function=0; In_Ready=0 while rst==0.
- In_Ready=1 in IDLE and FILL only (decoded from registered state); 0 otherwise.
- States: IDLE, FILL, PAD, ZERO, LEN, ISSUE, WAIT. All transfers are one byte per cycle.
- IDLE:
  - On an accepted byte: write Data_Block[0], index=1, bitcnt=8, first=1.
  - Go to FILL; if In_Last is also set, go to PAD.
- FILL:
  - Each accepted byte writes Data_Block[index]; index++; bitcnt+=8, wrapping mod 2^CNT_W.
  - If the byte fills index NB_BYTES-1: go to ISSUE, and set pad_pending=1 if it was In_Last.
  - Else if In_Last: go to PAD.
  - No accepted byte: hold.
- PAD:
  - Write 0x80 at index; index++.
  - If index (after increment) <= NB_BYTES-LEN_BYTES: go to ZERO with target NB_BYTES-LEN_BYTES, then LEN.
  - Else: ZERO fills to NB_BYTES, then ISSUE, with the length-only block still owed.
- ZERO: write 0x00 per cycle until the target index is reached.
- LEN: write bitcnt big-endian into bytes NB_BYTES-LEN_BYTES .. NB_BYTES-1, MSB first; then ISSUE with final=1.
- ISSUE (one cycle):
  - Enable=1; Function = first ? 0 : 1; then clear first.
  - Go to WAIT.
- WAIT:
  - Data_Block held stable; Enable=0.
  - On Core_Ready==1: index=0, then:
    - if pad_pending: PAD (0x80 at byte 0);
    - else if the owed length-only block is pending: ZERO to NB_BYTES-LEN_BYTES, then LEN;
    - else if final: IDLE;
    - else: FILL.
- Enable is never asserted twice for one buffer. Core_Ready is ignored outside WAIT.
- Bytes are never lost: In_Ready=0 in PAD/ZERO/LEN/ISSUE/WAIT.
- Block count per message: ceil((n+1+LEN_BYTES)/NB_BYTES).
- Reset mid-operation: partial message discarded; Enable does not pulse; next message starts with Function=0.

Optional Feature:
- Macro SHA_PAD_BYPASS_EN.
- Defined:
  - Adds input Pad_Bypass (1 bit), sampled on the first accepted byte of each message.
  - With Pad_Bypass=1, In_Last skips PAD/LEN. A partial block is zero-filled (ZERO to NB_BYTES) and issued as final. A full block is issued directly. No 0x80 and no length bytes are appended.
- Undefined: port absent; padding always applied.

Test Plan:
- "abc" (0x61,0x62,0x63, In_Last on 0x63) -> one Enable pulse, Function=0; bytes 0..3 = 61 62 63 80; 4..55 = 00; 56..63 = 00..00 00 18.
- 55 bytes of 0x00 -> one block; byte 55=0x80; length bytes = 00..01 B8; returns to IDLE after Core_Ready.
- 56 bytes -> two blocks (Function 0 then 1); block1 byte 56=0x80, rest 00; block2 all 00 except length 00..01 C0.
- 64 bytes -> block1 = data; block2 byte 0=0x80, length 00..02 00, Function=1; In_Ready=0 between blocks.
- Core_Ready held 0 for 20 cycles after ISSUE -> Data_Block stable, Enable single pulse, In_Ready=0; Core_Ready=1 -> next block proceeds.
- Reset asserted after 30 bytes -> Data_Block=00, Enable=0; new "abc" message gives the same result as the first scenario with Function=0.
